// File: rtl/procb_buf_if.sv
// -----------------------------------------------------------------------------
// procb_buf_if
// Bundles the writer-side and reader-side signals of the per-thread procb
// record store.
//   master : thread-side writer plus procb reader (drives enables, thread
//            numbers and records; observes wr_full, lookup_empty, dout, err)
//   slave  : the record store itself (procb_buf)
// Signals:
//   wr_thread_num, wr_en, din : push one record into a thread's queue
//   wr_full                   : queue of wr_thread_num is full (combinational)
//   rd_thread_num             : thread selected by the reader
//   lookup_en                 : read-ahead of the next unlooked record
//   rd_en, rd_rst             : commit the previous lookup / clear the thread
//   lookup_empty              : no unlooked record for rd_thread_num
//   dout                      : registered looked-up record
//   err                       : sticky protocol error
// -----------------------------------------------------------------------------
interface procb_buf_if #(
  parameter int N_THREADS_MSB = 2,
  parameter int PROCB_D_WIDTH = 32
);
  logic [N_THREADS_MSB:0] wr_thread_num;
  logic                   wr_en;
  logic [PROCB_D_WIDTH-1:0] din;
  logic                   wr_full;
  logic [N_THREADS_MSB:0] rd_thread_num;
  logic                   lookup_en;
  logic                   rd_en;
  logic                   rd_rst;
  logic                   lookup_empty;
  logic [PROCB_D_WIDTH-1:0] dout;
  logic                   err;

  modport master (
    output wr_thread_num, wr_en, din, rd_thread_num, lookup_en, rd_en, rd_rst,
    input  wr_full, lookup_empty, dout, err
  );

  modport slave (
    input  wr_thread_num, wr_en, din, rd_thread_num, lookup_en, rd_en, rd_rst,
    output wr_full, lookup_empty, dout, err
  );
endinterface

// File: rtl/procb_buf.sv
// -----------------------------------------------------------------------------
// procb_buf
// Per-thread circular store of process_bytes records {addr, bytes_left,
// finish_ctx} feeding the md5 procb reader. Each thread owns PROCB_DEPTH
// slots of a shared distributed RAM. The reader does a speculative lookup
// (lookup_en) and commits it (rd_en) in the following cycle; an uncommitted
// lookup is rolled back so the same record is presented again.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous, active-high; overrides every other input
//   bus   : procb_buf_if slave modport (write side, read side, status)
// -----------------------------------------------------------------------------
module procb_buf #(
  parameter int N_THREADS     = 8,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int PROCB_DEPTH   = 4,   // power of 2, >= 2
  parameter int PROCB_D_WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  procb_buf_if.slave bus
);

  localparam int AW        = $clog2(PROCB_DEPTH);  // slot index bits
  localparam int PW        = AW + 1;               // pointer with wrap bit
  localparam int TW        = N_THREADS_MSB + 1;
  localparam int MW        = TW + AW;
  localparam int N_ENTRIES = N_THREADS * PROCB_DEPTH;

  typedef logic [PW-1:0]            ptr_t;
  typedef logic [TW-1:0]            thr_t;
  typedef logic [PROCB_D_WIDTH-1:0] rec_t;

  rec_t mem [N_ENTRIES];

  ptr_t wp_q [N_THREADS];
  ptr_t wp_d [N_THREADS];
  ptr_t rp_q [N_THREADS];
  ptr_t rp_d [N_THREADS];
  ptr_t lp_q [N_THREADS];
  ptr_t lp_d [N_THREADS];

  logic pend_q, pend_d;
  thr_t pend_thread_q, pend_thread_d;
  rec_t dout_q, dout_d;
  logic err_q, err_d;

  thr_t          wr_t;
  thr_t          rd_t;
  ptr_t          base;
  logic          rollback;
  logic          lookup_empty;
  logic          wr_full;
  logic          lookup_ok;
  logic          commit_ok;
  logic          mem_we;
  logic [MW-1:0] mem_waddr;
  logic [MW-1:0] mem_raddr;

  assign wr_t = bus.wr_thread_num;
  assign rd_t = bus.rd_thread_num;

  // Lookup base and status flags
  always_comb begin
    // NOTE: every always_comb output gets a default assignment first so no
    // path through the block can leave it unassigned and infer a latch.
    rollback     = pend_q & ~bus.rd_en;
    // An uncommitted lookup on this thread is undone this cycle, so the
    // next record to present is the committed one, not lp.
    base         = (rollback && (pend_thread_q == rd_t)) ? rp_q[rd_t] : lp_q[rd_t];
    lookup_empty = (base == wp_q[rd_t]);
    wr_full      = ((wp_q[wr_t] - rp_q[wr_t]) == ptr_t'(PROCB_DEPTH));
    lookup_ok    = bus.lookup_en & ~lookup_empty;
    commit_ok    = bus.rd_en & ~bus.rd_rst & pend_q & (pend_thread_q == rd_t);
    mem_we       = bus.wr_en & ~wr_full & ~RESET;
    mem_waddr    = {wr_t, wp_q[wr_t][AW-1:0]};
    mem_raddr    = {rd_t, base[AW-1:0]};
  end

  // Next-state logic
  always_comb begin
    wp_d          = wp_q;
    rp_d          = rp_q;
    lp_d          = lp_q;
    pend_d        = bus.lookup_en;
    pend_thread_d = rd_t;
    dout_d        = dout_q;
    err_d         = err_q;

    if (bus.wr_en) begin
      if (wr_full) err_d = 1'b1;
      else         wp_d[wr_t] = wp_q[wr_t] + ptr_t'(1);
    end

    if (rollback) lp_d[pend_thread_q] = rp_q[pend_thread_q];

    // A lookup on the rolled-back thread already started from rp, so its
    // lp update below supersedes the plain rollback above.
    if (bus.lookup_en) begin
      if (lookup_empty) begin
        err_d = 1'b1;
      end else begin
        dout_d     = mem[mem_raddr];
        lp_d[rd_t] = base + ptr_t'(1);
      end
    end

    if (bus.rd_en && !bus.rd_rst) begin
      if (commit_ok) rp_d[rd_t] = rp_q[rd_t] + ptr_t'(1);
      else           err_d = 1'b1;
    end

    // Thread clear comes last so it wins over any same-cycle pointer update.
    if (bus.rd_en && bus.rd_rst) begin
      wp_d[rd_t] = '0;
      rp_d[rd_t] = '0;
      lp_d[rd_t] = '0;
      pend_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int t = 0; t < N_THREADS; t++) begin
        wp_q[t] <= '0;
        rp_q[t] <= '0;
        lp_q[t] <= '0;
      end
      pend_q        <= 1'b0;
      pend_thread_q <= '0;
      dout_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      lp_q          <= lp_d;
      pend_q        <= pend_d;
      pend_thread_q <= pend_thread_d;
      dout_q        <= dout_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the record RAM is deliberately not reset; pointers define which
  // slots are valid, and a reset would stop it mapping onto distributed RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= bus.din;
  end

  assign bus.wr_full      = wr_full;
  assign bus.lookup_empty = lookup_empty;
  assign bus.dout         = dout_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_procb_buf.sv
// -----------------------------------------------------------------------------
// tb_procb_buf
// Directed scenarios followed by randomized traffic for procb_buf. Expected
// values come from a queue-per-thread reference model: each thread is a list
// of uncommitted records plus a count of records already looked ahead.
// -----------------------------------------------------------------------------
module tb_procb_buf;
  localparam int NT    = 8;
  localparam int TMSB  = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  procb_buf_if #(.N_THREADS_MSB(TMSB), .PROCB_D_WIDTH(DW)) bus ();

  procb_buf #(
    .N_THREADS    (NT),
    .N_THREADS_MSB(TMSB),
    .PROCB_DEPTH  (DEPTH),
    .PROCB_D_WIDTH(DW)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [DW-1:0] rec_q_t [$];
  rec_q_t        mq [NT];   // records written but not yet committed, oldest first
  int            la [NT];   // how many of them the reader has looked ahead
  bit            m_pend;
  bit            m_pend_ok;
  int            m_pend_thr;
  logic [DW-1:0] m_dout;
  bit            m_err;

  function automatic int look_off(input int rt, input bit re);
    if (m_pend && !re && m_pend_thr == rt) return 0;
    return la[rt];
  endfunction

  function automatic bit exp_empty(input int rt, input bit re);
    return look_off(rt, re) >= mq[rt].size();
  endfunction

  function automatic bit exp_full(input int wt);
    return mq[wt].size() == DEPTH;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      mq[t].delete();
      la[t] = 0;
    end
    m_pend = 0; m_pend_ok = 0; m_pend_thr = 0; m_dout = '0; m_err = 0;
  endtask

  task automatic model_step(input bit we, input int wt, input logic [DW-1:0] d,
                            input bit le, input bit re, input bit rr, input int rt,
                            input bit rs);
    bit rollback, empty, full, look_ok, commit_ok;
    int boff;
    if (rs) begin
      model_reset();
      return;
    end
    rollback  = m_pend && !re;
    boff      = look_off(rt, re);
    empty     = exp_empty(rt, re);
    full      = exp_full(wt);
    look_ok   = le && !empty;
    commit_ok = re && !rr && m_pend && m_pend_thr == rt;
    if (le && empty) m_err = 1;
    if (re && !rr && !commit_ok) m_err = 1;
    if (we && full) m_err = 1;
    if (look_ok) m_dout = mq[rt][boff];
    if (rollback) la[m_pend_thr] = 0;
    if (look_ok) la[rt] = boff + 1;
    if (commit_ok) begin
      mq[rt].delete(0);
      la[rt]--;
    end
    if (we && !full) mq[wt].push_back(d);
    m_pend     = le;
    m_pend_ok  = look_ok;
    m_pend_thr = rt;
    if (re && rr) begin
      mq[rt].delete();
      la[rt] = 0;
      m_pend = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock cycle: drive, compare all outputs at the falling edge, then
  // advance the model on the rising edge and return 1 ns after it.
  task automatic cyc(input bit we, input int wt, input logic [DW-1:0] d,
                     input bit le, input bit re, input bit rr, input int rt,
                     input bit rs);
    bus.wr_en         = we;
    bus.wr_thread_num = wt[TMSB:0];
    bus.din           = d;
    bus.lookup_en     = le;
    bus.rd_en         = re;
    bus.rd_rst        = rr;
    bus.rd_thread_num = rt[TMSB:0];
    rst               = rs;
    @(negedge clk);
    check("lookup_empty", DW'(bus.lookup_empty), DW'(exp_empty(rt, re)));
    check("wr_full", DW'(bus.wr_full), DW'(exp_full(wt)));
    check("dout", bus.dout, m_dout);
    check("err", DW'(bus.err), DW'(m_err));
    @(posedge clk);
    model_step(we, wt, d, le, re, rr, rt, rs);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic wr(input int wt, input logic [DW-1:0] d);
    cyc(1'b1, wt, d, 1'b0, 1'b0, 1'b0, wt, 1'b0);
  endtask

  task automatic rd(input int rt, input bit le, input bit re);
    cyc(1'b0, 0, '0, le, re, 1'b0, rt, 1'b0);
  endtask

  logic [DW-1:0] rec_a [5];
  logic [DW-1:0] rec_b [2];
  logic [DW-1:0] rec_c [4];
  logic [DW-1:0] rec_d [6];
  logic [DW-1:0] rec_e;

  bit            s_clean, s_we, s_le, s_re, s_rr, s_rs;
  int            s_span, s_wt, s_rt;
  logic [DW-1:0] s_d;

  initial begin
    bus.wr_en = 1'b0; bus.wr_thread_num = '0; bus.din = '0;
    bus.lookup_en = 1'b0; bus.rd_en = 1'b0; bus.rd_rst = 1'b0; bus.rd_thread_num = '0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) rec_a[i] = $urandom();
    for (int i = 0; i < 2; i++) rec_b[i] = $urandom();
    for (int i = 0; i < 4; i++) rec_c[i] = $urandom();
    for (int i = 0; i < 6; i++) rec_d[i] = $urandom();
    rec_e = $urandom();

    // Reset state
    do_reset();
    check("rst_dout", bus.dout, '0);
    check("rst_err", DW'(bus.err), '0);
    check("rst_empty", DW'(bus.lookup_empty), DW'(1));
    check("rst_full", DW'(bus.wr_full), '0);

    // Fill and drain thread 3
    for (int i = 0; i < 4; i++) wr(3, rec_a[i]);
    check("fill_full", DW'(bus.wr_full), DW'(1));
    check("fill_no_err", DW'(bus.err), '0);
    wr(3, rec_a[4]);
    check("drop_err", DW'(bus.err), DW'(1));
    rd(3, 1'b1, 1'b0);
    check("drain_a0", bus.dout, rec_a[0]);
    for (int i = 1; i < 4; i++) begin
      rd(3, 1'b1, 1'b1);
      check($sformatf("drain_a%0d", i), bus.dout, rec_a[i]);
    end
    rd(3, 1'b0, 1'b1);
    check("drain_empty", DW'(bus.lookup_empty), DW'(1));

    // Rollback on thread 1
    do_reset();
    wr(1, rec_b[0]);
    wr(1, rec_b[1]);
    rd(1, 1'b1, 1'b0);
    check("rb_first", bus.dout, rec_b[0]);
    rd(1, 1'b0, 1'b0);
    check("rb_not_empty", DW'(bus.lookup_empty), '0);
    rd(1, 1'b1, 1'b0);
    check("rb_replay", bus.dout, rec_b[0]);
    // Rollback with a simultaneous lookup on the same thread
    rd(1, 1'b1, 1'b0);
    check("rb_with_lookup", bus.dout, rec_b[0]);
    rd(1, 1'b1, 1'b1);
    check("rb_lp_next", bus.dout, rec_b[1]);
    rd(1, 1'b0, 1'b1);
    check("rb_drained", DW'(bus.lookup_empty), DW'(1));
    check("rb_no_err", DW'(bus.err), '0);

    // Interleaved threads 0 and 5 while writing thread 5
    for (int i = 0; i < 4; i++) wr(0, rec_c[i]);
    wr(5, rec_d[0]);
    wr(5, rec_d[1]);
    for (int r = 0; r < 4; r++) begin
      cyc(1'b1, 5, rec_d[r+2], 1'b1, 1'b0, 1'b0, 0, 1'b0);
      check($sformatf("il_t0_%0d", r), bus.dout, rec_c[r]);
      rd(0, 1'b0, 1'b1);
      rd(5, 1'b1, 1'b0);
      check($sformatf("il_t5_%0d", r), bus.dout, rec_d[r]);
      rd(5, 1'b0, 1'b1);
    end
    check("il_no_err", DW'(bus.err), '0);

    // Init sweep with stale records in threads 2 and 5
    wr(2, rec_e);
    for (int t = 0; t < NT; t++) cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b1, t, 1'b0);
    check("sweep_err", DW'(bus.err), '0);
    for (int t = 0; t < NT; t++) begin
      rd(t, 1'b0, 1'b0);
      check($sformatf("sweep_empty_%0d", t), DW'(bus.lookup_empty), DW'(1));
    end

    // Commit without lookup, then reset with competing inputs
    wr(2, rec_e);
    rd(2, 1'b0, 1'b1);
    check("bad_commit_err", DW'(bus.err), DW'(1));
    rd(2, 1'b1, 1'b0);
    check("bad_commit_rp", bus.dout, rec_e);
    rd(2, 1'b0, 1'b1);
    cyc(1'b1, 4, rec_a[0], 1'b1, 1'b0, 1'b0, 2, 1'b1);
    check("reset_err", DW'(bus.err), '0);
    check("reset_dout", bus.dout, '0);
    for (int t = 0; t < NT; t++) begin
      rd(t, 1'b0, 1'b0);
      check($sformatf("reset_empty_%0d", t), DW'(bus.lookup_empty), DW'(1));
    end

    // Randomized traffic; even segments stay protocol-clean so err must hold 0
    for (int seg = 0; seg < 6; seg++) begin
      s_clean = (seg % 2) == 0;
      s_span  = (seg < 3) ? 3 : NT - 1;
      do_reset();
      for (int i = 0; i < 400; i++) begin
        s_wt = int'($urandom_range(0, s_span));
        s_rt = int'($urandom_range(0, s_span));
        s_d  = $urandom();
        s_we = ($urandom_range(0, 1) == 1);
        s_le = ($urandom_range(0, 9) < 6);
        s_re = 0; s_rr = 0; s_rs = 0;
        if (m_pend && m_pend_ok && $urandom_range(0, 9) < 7) begin
          s_re = 1;
          s_rt = m_pend_thr;
        end else if (!s_clean && $urandom_range(0, 19) == 0) begin
          s_re = 1;
          s_rr = 1;
        end else if (!s_clean && $urandom_range(0, 19) == 0) begin
          s_re = 1;
        end
        if (s_re && !s_rr && m_pend && !m_pend_ok && m_pend_thr == s_rt) s_re = 0;
        if (s_rr && s_we && s_wt == s_rt) s_we = 0;
        if (s_clean) begin
          if (s_le && exp_empty(s_rt, s_re)) s_le = 0;
          if (s_we && exp_full(s_wt)) s_we = 0;
        end else if ($urandom_range(0, 99) == 0) begin
          s_rs = 1;
        end
        cyc(s_we, s_wt, s_d, s_le, s_re, s_rr, s_rt, s_rs);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
